seq_split_multiplier: RTL and testbench

Sequential unsigned multiplier for 2*HALF_W-bit operands. It reuses one combinational HALF_W x HALF_W Dadda core across successive cycles to accumulate four partial products: HH, HL, LH, LL. A per-transaction approximate mode skips the LL partial product, saving one cycle at the cost of low-order accuracy. It sits between operand sources and consumers via valid/ready handshakes and is the reusable multiplier for approximate-computing datapaths.

---
 rtl/seq_split_multiplier_pkg.sv | 14 +
 rtl/nbit_dadda_multiplier.sv | 83 ++++++++
 rtl/seq_split_multiplier.sv | 99 +++++++++
 tb/tb_seq_split_multiplier.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_split_multiplier_pkg.sv
// seq_split_multiplier_pkg: shared width default, shift constants and FSM encoding
package seq_split_multiplier_pkg;
    localparam int HALF_W_DEF = 4;
    localparam int SH_MID = HALF_W_DEF;
    localparam int SH_HI = 2 * HALF_W_DEF;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P_HH = 3'd1,
        P_HL = 3'd2,
        P_LH = 3'd3,
        P_LL = 3'd4,
        DONE = 3'd5
    } state_e;
endpackage

// File: rtl/nbit_dadda_multiplier.sv
// nbit_dadda_multiplier: combinational N x N -> 2N unsigned Dadda-tree multiplier
module nbit_dadda_multiplier #(
    parameter int N = 4
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);
    localparam int C = 2 * N;
    localparam int H = N + 2;
    localparam int STAGES = 8;
    function automatic int dseq(input int s);
        int d;
        d = 2;
        for (int k = 0; k < s; k++) d = d * 3 / 2;
        return d;
    endfunction
    logic [H-1:0] col [C];
    logic [H-1:0] nxt [C];
    int h [C];
    int nh [C];
    logic [H-1:0] t;
    logic [C-1:0] r0, r1;
    logic x, y, z, sb, c, fa;
    int p, d;
    always_comb begin
        t = '0; x = 1'b0; y = 1'b0; z = 1'b0; sb = 1'b0; c = 1'b0; fa = 1'b0; p = 0; d = 0;
        for (int i = 0; i < C; i++) begin
            col[i] = '0;
            nxt[i] = '0;
            h[i] = 0;
            nh[i] = 0;
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                col[i+j] = col[i+j] | (H'(a_i[i] & b_i[j]) << h[i+j]);
                h[i+j] = h[i+j] + 1;
            end
        // Each stage squeezes every column down to the next Dadda height d
        for (int s = STAGES - 1; s >= 0; s--) begin
            d = dseq(s);
            for (int i = 0; i < C; i++) begin
                nxt[i] = '0;
                nh[i] = 0;
            end
            for (int i = 0; i < C; i++) begin
                p = 0;
                for (int k = 0; k < H; k++)
                    if (h[i] - p + nh[i] > d) begin
                        t = col[i] >> p;
                        fa = (h[i] - p + nh[i] > d + 1);
                        x = t[0];
                        y = t[1];
                        z = fa & t[2];
                        sb = x ^ y ^ z;
                        c = (x & y) | (x & z) | (y & z);
                        nxt[i] = nxt[i] | (H'(sb) << nh[i]);
                        nh[i] = nh[i] + 1;
                        if (i + 1 < C) begin
                            nxt[i+1] = nxt[i+1] | (H'(c) << nh[i+1]);
                            nh[i+1] = nh[i+1] + 1;
                        end
                        p = p + (fa ? 3 : 2);
                    end
                for (int k = 0; k < H; k++)
                    if (k >= p && k < h[i]) begin
                        t = col[i] >> k;
                        nxt[i] = nxt[i] | (H'(t[0]) << nh[i]);
                        nh[i] = nh[i] + 1;
                    end
            end
            for (int i = 0; i < C; i++) begin
                col[i] = nxt[i];
                h[i] = nh[i];
            end
        end
        for (int i = 0; i < C; i++) begin
            r0[i] = col[i][0];
            r1[i] = col[i][1];
        end
        p_o = r0 + r1;
    end
endmodule

// File: rtl/seq_split_multiplier.sv
// seq_split_multiplier: 2*HALF_W-bit unsigned multiplier accumulating four half-products
// through one shared Dadda core, with an optional approximate mode that skips LL.
module seq_split_multiplier
    import seq_split_multiplier_pkg::*;
#(
    parameter int HALF_W = HALF_W_DEF,
    parameter bit APPROX_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   a_in,
    input  logic [2*HALF_W-1:0]   b_in,
    input  logic                  approx_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*HALF_W-1:0]   product,
    output logic                  approx_out
);
    localparam int W = 2 * HALF_W;
    localparam int P = 4 * HALF_W;
    state_e state_q;
    logic [W-1:0] a_q, b_q, pp;
    logic [P-1:0] acc_q, acc_d, product_q, pp_shift;
    logic [HALF_W-1:0] op_a, op_b;
    logic approx_q, out_valid_q, approx_out_q, hi_a, hi_b;
    always_comb begin
        hi_a = (state_q == P_HH) || (state_q == P_HL);
        hi_b = (state_q == P_HH) || (state_q == P_LH);
        op_a = hi_a ? a_q[W-1:HALF_W] : a_q[HALF_W-1:0];
        op_b = hi_b ? b_q[W-1:HALF_W] : b_q[HALF_W-1:0];
        pp_shift = (state_q == P_HH) ? (P'(pp) << W) :
                   (state_q == P_LL) ? P'(pp) : (P'(pp) << HALF_W);
        acc_d = acc_q + pp_shift;
    end
    nbit_dadda_multiplier #(.N(HALF_W)) u_core (
        .a_i(op_a),
        .b_i(op_b),
        .p_o(pp)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            approx_q <= 1'b0;
            acc_q <= '0;
            product_q <= '0;
            out_valid_q <= 1'b0;
            approx_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q <= a_in;
                    b_q <= b_in;
                    approx_q <= approx_in & APPROX_EN;
                    acc_q <= '0;
                    state_q <= P_HH;
                end
                P_HH: begin
                    acc_q <= acc_d;
                    state_q <= P_HL;
                end
                P_HL: begin
                    acc_q <= acc_d;
                    state_q <= P_LH;
                end
                P_LH: begin
                    acc_q <= acc_d;
                    if (approx_q) begin
                        product_q <= acc_d;
                        approx_out_q <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        state_q <= P_LL;
                    end
                end
                P_LL: begin
                    acc_q <= acc_d;
                    product_q <= acc_d;
                    approx_out_q <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign product = product_q;
    assign approx_out = approx_out_q;
endmodule

// File: tb/tb_seq_split_multiplier.sv
// tb_seq_split_multiplier: directed scoreboard bench for the split multiplier
module tb_seq_split_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic approx_in = 1'b0;
    logic out_ready = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic in_ready, out_valid, approx_out;
    logic [15:0] product;
    logic z_in_ready, z_out_valid, z_approx_out;
    logic [15:0] z_product;
    typedef struct {
        logic [15:0] p;
        logic ap;
        int lat;
    } exp_t;
    exp_t q[$];
    int total = 0;
    int bad = 0;
    logic [15:0] last_p;
    always #5 clk = ~clk;
    seq_split_multiplier #(.HALF_W(4), .APPROX_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .approx_in(approx_in), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .approx_out(approx_out)
    );
    seq_split_multiplier #(.HALF_W(4), .APPROX_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
        .a_in(a_in), .b_in(b_in), .approx_in(approx_in), .out_valid(z_out_valid),
        .out_ready(out_ready), .product(z_product), .approx_out(z_approx_out)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ap);
        exp_t e;
        logic [3:0] al, bl;
        al = a[3:0];
        bl = b[3:0];
        e.p = ({8'd0, a} * {8'd0, b}) - (ap ? ({12'd0, al} * {12'd0, bl}) : 16'd0);
        e.ap = ap;
        e.lat = ap ? 3 : 4;
        q.push_back(e);
        @(negedge clk);
        a_in = a;
        b_in = b;
        approx_in = ap;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        approx_in = 1'($urandom);
    endtask
    task automatic recv(input string tag, input int start);
        exp_t e;
        int lat;
        lat = start;
        e = q.pop_front();
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        chk({tag, "_prod"}, 32'(product), 32'(e.p));
        chk({tag, "_apx"}, 32'(approx_out), 32'(e.ap));
        last_p = e.p;
    endtask
    task automatic ack(input logic keep);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_in_ready", 32'(in_ready), 32'd1);
        chk("ack_out_valid", 32'(out_valid), 32'd0);
        out_ready = keep;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_approx_out", 32'(approx_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'hFF, 8'hFF, 1'b0);
        recv("exact_ff", 0);
        ack(1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        recv("approx_ff", 0);
        chk("en0_not_yet", 32'(z_out_valid), 32'd0);
        ack(1'b0);
        chk("en0_valid", 32'(z_out_valid), 32'd1);
        chk("en0_prod", 32'(z_product), 32'hFE01);
        chk("en0_apx", 32'(z_approx_out), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("en0_drained", 32'(z_in_ready), 32'd1);
        chk("idle_ready_noeffect", 32'(out_valid), 32'd0);
        send(8'hA5, 8'h3C, 1'b0);
        recv("mix_exact", 0);
        ack(1'b0);
        send(8'hA5, 8'h3C, 1'b1);
        recv("mix_approx", 0);
        ack(1'b0);
        send(8'h00, 8'hFF, 1'b0);
        recv("zero", 0);
        ack(1'b0);
        send(8'h12, 8'h34, 1'b0);
        recv("bp", 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_prod", 32'(product), 32'(last_p));
        end
        ack(1'b0);
        send(8'h9C, 8'h7B, 1'b0);
        in_valid = 1'b1;
        a_in = 8'h11;
        b_in = 8'h11;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("busy_in_ready2", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        recv("busy", 1);
        ack(1'b0);
        send(8'hFF, 8'hFF, 1'b0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_product", 32'(product), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        send(8'h02, 8'h03, 1'b0);
        recv("post_rst", 0);
        ack(1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] ra, rb;
            logic rp;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = 1'($urandom);
            send(ra, rb, rp);
            recv("b2b", 0);
            ack(1'b1);
        end
        out_ready = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
